encode_scan_ctrl: RTL

Scan sequencer and stream packer that sits between `encode_process` (the precise-encode interpolator) and the encode TX FIFO / aurora path. It arms on a scan start, waits for the W encoder zero crossing, decimates the precise encode strobe by a programmable alignment count, and buffers the {W, X} samples into a 64-bit AXI-stream. On scan stop it appends a trailer word carrying the packet and drop counts.

---
 rtl/encode_scan_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/encode_scan_ctrl.sv
// encode_scan_ctrl
// Scan sequencer and stream packer placed between encode_process and the
// encode TX FIFO. A scan arms on scan_start_i, waits for a W zero crossing
// on the masked W bits, then decimates the precise encode strobe by the
// latched alignment count. Each emitted sample is packed as {W, X} into a
// 64-bit stream word. On scan_stop_i a trailer word
// {16'hEEEE, drop_cnt, pack_cnt} with tlast=1 is appended.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   scan_start_i/stop_i   one-cycle scan control pulses
//   align_set_i           strobes per emitted sample (0 behaves as 1)
//   precise_encode_*      strobe plus W (unsigned) and X (signed) values
//   tx_t*                 64-bit AXI-stream master, tkeep constant 8'hFF
//   pack_cnt_o/drop_cnt_o words pushed / samples dropped in current or last scan
//   state_o, busy_o       FSM state (IDLE=0 ARM=1 RUN=2 FLUSH=3 DRAIN=4)
//
// Stream handshake: a word transfers on a cycle where tx_tvalid_o and
// tx_tready_i are both high; while tx_tvalid_o is high and tx_tready_i is
// low, tx_tdata_o and tx_tlast_o hold their values.
module encode_scan_ctrl #(
  parameter int ENCODE_WID      = 32,
  parameter int ENCODE_MASK_WID = 18,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  scan_start_i,
  input  logic                  scan_stop_i,
  input  logic [31:0]           align_set_i,
  input  logic                  precise_encode_en_i,
  input  logic [ENCODE_WID-1:0] precise_encode_w_i,
  input  logic [ENCODE_WID-1:0] precise_encode_x_i,
  output logic [63:0]           tx_tdata_o,
  output logic                  tx_tvalid_o,
  input  logic                  tx_tready_i,
  output logic                  tx_tlast_o,
  output logic [7:0]            tx_tkeep_o,
  output logic [31:0]           pack_cnt_o,
  output logic [15:0]           drop_cnt_o,
  output logic [2:0]            state_o,
  output logic                  busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t                     r_state;
  logic [31:0]                r_align;
  logic [31:0]                r_dcnt;
  logic [31:0]                r_pack_cnt;
  logic [15:0]                r_drop_cnt;
  logic [ENCODE_MASK_WID-1:0] r_w_prev;
  logic                       r_w_prev_valid;

  // FIFO storage: bit 64 is tlast, bits 63:0 are tdata.
  logic [64:0]                r_mem [FIFO_DEPTH];
  logic [AW-1:0]              r_wr_ptr;
  logic [AW-1:0]              r_rd_ptr;
  logic [AW:0]                r_count;

  logic [ENCODE_MASK_WID-1:0] w_w_masked;
  logic                       w_full;
  logic                       w_pop;
  logic                       w_cross;
  logic                       w_emit_run;
  logic                       w_push_req;
  logic                       w_push_data;
  logic                       w_push_ok;
  logic [64:0]                w_push_word;

  assign w_w_masked = precise_encode_w_i[ENCODE_MASK_WID-1:0];
  // Full is judged on occupancy before any pop in the same cycle.
  assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop      = (r_count != '0) && tx_tready_i;

  // A stop in ARM takes priority over a crossing in the same cycle.
  assign w_cross    = (r_state == S_ARM) && precise_encode_en_i && !scan_stop_i &&
                      r_w_prev_valid && (w_w_masked < r_w_prev);
  assign w_emit_run = (r_state == S_RUN) && precise_encode_en_i && (r_dcnt == 32'd0);

  always_comb begin
    w_push_req  = 1'b0;
    w_push_word = '0;
    if (w_cross || w_emit_run) begin
      w_push_req  = 1'b1;
      w_push_word = {1'b0, precise_encode_w_i[31:0], precise_encode_x_i[31:0]};
    end else if (r_state == S_FLUSH) begin
      w_push_req  = 1'b1;
      w_push_word = {1'b1, 16'hEEEE, r_drop_cnt, r_pack_cnt};
    end
  end

  assign w_push_data = w_push_req && (r_state != S_FLUSH);
  assign w_push_ok   = w_push_req && !w_full;

  // First-word-fall-through buffer; the head entry drives the stream.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= w_push_word;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= S_IDLE;
      r_align        <= 32'd1;
      r_dcnt         <= 32'd0;
      r_pack_cnt     <= 32'd0;
      r_drop_cnt     <= 16'd0;
      r_w_prev       <= '0;
      r_w_prev_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (scan_start_i) begin
            r_align        <= (align_set_i == 32'd0) ? 32'd1 : align_set_i;
            r_dcnt         <= 32'd0;
            r_pack_cnt     <= 32'd0;
            r_drop_cnt     <= 16'd0;
            r_w_prev_valid <= 1'b0;
            r_state        <= S_ARM;
          end
        end
        S_ARM: begin
          if (scan_stop_i) begin
            r_state <= S_IDLE;
          end else if (precise_encode_en_i) begin
            r_w_prev       <= w_w_masked;
            r_w_prev_valid <= 1'b1;
            if (w_cross) begin
              r_dcnt  <= r_align - 32'd1;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (precise_encode_en_i) begin
            if (r_dcnt == 32'd0) r_dcnt <= r_align - 32'd1;
            else                 r_dcnt <= r_dcnt - 32'd1;
          end
          if (scan_stop_i) r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (!w_full) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (r_count == '0) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Data pushes only occur in ARM/RUN, so this never collides with the
      // counter clear on start.
      if (w_push_data) begin
        if (w_push_ok)                    r_pack_cnt <= r_pack_cnt + 32'd1;
        else if (r_drop_cnt != 16'hFFFF)  r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign tx_tdata_o  = r_mem[r_rd_ptr][63:0];
  assign tx_tlast_o  = r_mem[r_rd_ptr][64];
  assign tx_tvalid_o = (r_count != '0);
  assign tx_tkeep_o  = 8'hFF;
  assign pack_cnt_o  = r_pack_cnt;
  assign drop_cnt_o  = r_drop_cnt;
  assign state_o     = r_state;
  assign busy_o      = (r_state != S_IDLE);

endmodule
